// File: rtl/tube_pkg.sv
// Shared constants for the seven-segment display controller:
// register offsets, blank pattern and the hex segment table.
package tube_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_EXT  = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost byte.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,
      8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99,
      8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/tube_ctrl_hex_to_seg.sv
// Combinational hex digit to active-low segment decoder.
// Decimal point is always off.
module hex_to_seg
   import tube_pkg::*;
(
   input  logic [3:0] hex,
   output logic [7:0] seg
);

   // Table lookup of the segment pattern for one hex digit.
   always_comb begin
      seg = SEG_TABLE[hex];
   end

endmodule

// File: rtl/tube_ctrl.sv
// Memory-mapped seven-segment controller: DATA/EXT/CTRL registers,
// scan divider and registered multiplexed segment/select outputs.
module tube_ctrl
   import tube_pkg::*;
#(
   parameter int SCAN_DIV = 25000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  digital_tube0,
   output logic [3:0]  digital_tube_sel0,
   output logic [7:0]  digital_tube1,
   output logic [3:0]  digital_tube_sel1,
   output logic [7:0]  digital_tube2,
   output logic        digital_tube_sel2
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

   logic [31:0]   data_q, data_d;
   logic [4:0]    ext_q, ext_d;
   logic          en_q, en_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    idx_q, idx_d;

   logic [7:0] tube0_q, tube0_d;
   logic [7:0] tube1_q, tube1_d;
   logic [7:0] tube2_q, tube2_d;
   logic [3:0] sel0_q, sel0_d;
   logic [3:0] sel1_q, sel1_d;
   logic       sel2_q, sel2_d;

   logic [15:0] data_hi;
   logic [3:0]  nib0, nib1;
   logic [7:0]  seg0, seg1, seg2;
   logic        tick;

   assign data_hi = data_q[31:16];
   assign nib0    = data_q[{idx_q, 2'b00} +: 4];
   assign nib1    = data_hi[{idx_q, 2'b00} +: 4];
   assign tick    = en_q && (div_q == DIV_MAX);

   hex_to_seg u_seg0 (.hex(nib0),       .seg(seg0));
   hex_to_seg u_seg1 (.hex(nib1),       .seg(seg1));
   hex_to_seg u_seg2 (.hex(ext_q[3:0]), .seg(seg2));

   // Register writes, scan divider/index advance and next pin values.
   always_comb begin
      data_d  = data_q;
      ext_d   = ext_q;
      en_d    = en_q;
      div_d   = div_q;
      idx_d   = idx_q;
      sel0_d  = 4'b0000;
      sel1_d  = 4'b0000;
      sel2_d  = 1'b0;
      tube0_d = SEG_BLANK;
      tube1_d = SEG_BLANK;
      tube2_d = SEG_BLANK;
      if (we) begin
         case (addr)
            ADDR_DATA: data_d = wdata;
            ADDR_EXT:  ext_d  = wdata[4:0];
            ADDR_CTRL: en_d   = wdata[0];
            default:   ;
         endcase
      end
      if (en_q) begin
         if (tick) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
         end else begin
            div_d = div_q + 1'b1;
         end
         sel0_d  = 4'b0001 << idx_q;
         sel1_d  = 4'b0001 << idx_q;
         tube0_d = seg0;
         tube1_d = seg1;
         sel2_d  = ext_q[4];
         tube2_d = ext_q[4] ? seg2 : SEG_BLANK;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         ext_q   <= '0;
         en_q    <= 1'b1;
         div_q   <= '0;
         idx_q   <= '0;
         sel0_q  <= '0;
         sel1_q  <= '0;
         sel2_q  <= 1'b0;
         tube0_q <= SEG_BLANK;
         tube1_q <= SEG_BLANK;
         tube2_q <= SEG_BLANK;
      end else begin
         data_q  <= data_d;
         ext_q   <= ext_d;
         en_q    <= en_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         sel0_q  <= sel0_d;
         sel1_q  <= sel1_d;
         sel2_q  <= sel2_d;
         tube0_q <= tube0_d;
         tube1_q <= tube1_d;
         tube2_q <= tube2_d;
      end
   end

   // Combinational register readback; unused bits and offset 3 read 0.
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_DATA: rdata = data_q;
         ADDR_EXT:  rdata = {27'd0, ext_q};
         ADDR_CTRL: rdata = {31'd0, en_q};
         default:   rdata = '0;
      endcase
   end

   assign digital_tube0     = tube0_q;
   assign digital_tube1     = tube1_q;
   assign digital_tube2     = tube2_q;
   assign digital_tube_sel0 = sel0_q;
   assign digital_tube_sel1 = sel1_q;
   assign digital_tube_sel2 = sel2_q;

endmodule

// File: tb/tb_tube_ctrl.sv
// Scoreboard bench for tube_ctrl: a frame-position reference model
// predicts every cycle's pins and readback; a monitor compares.
module tb_tube_ctrl;

   localparam int SD = 4;
   localparam int FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
   logic [3:0]  digital_tube_sel0, digital_tube_sel1;
   logic        digital_tube_sel2;

   tube_ctrl #(.SCAN_DIV(SD)) dut (
      .clk(clk),
      .reset(reset),
      .we(we),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .digital_tube0(digital_tube0),
      .digital_tube_sel0(digital_tube_sel0),
      .digital_tube1(digital_tube1),
      .digital_tube_sel1(digital_tube_sel1),
      .digital_tube2(digital_tube2),
      .digital_tube_sel2(digital_tube_sel2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [36:0] disp;
      logic [31:0] data;
      logic [4:0]  ext;
      logic        en;
   } exp_t;

   exp_t q[$];

   logic [7:0] segt [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   localparam logic [36:0] BLANK = {4'b0, 8'hFF, 4'b0, 8'hFF, 1'b0, 8'hFF};

   int n_checks = 0;
   int n_fails = 0;

   // Reference: registers plus position within the enabled frame.
   logic [31:0] m_data;
   logic [4:0]  m_ext;
   logic        m_en;
   int          m_p;
   bit          known = 0;

   function automatic logic [36:0] predict();
      int i;
      logic [3:0] s;
      logic [7:0] t2;
      if (!m_en) return BLANK;
      i = m_p / SD;
      s = 4'(1 << i);
      t2 = m_ext[4] ? segt[m_ext[3:0]] : 8'hFF;
      return {s, segt[(m_data >> (4 * i)) & 32'hF],
              s, segt[(m_data >> (16 + 4 * i)) & 32'hF],
              m_ext[4], t2};
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (reset) begin
            known = 1;
            m_data = 0;
            m_ext = 0;
            m_en = 1;
            m_p = 0;
            e.disp = BLANK;
         end else if (known) begin
            e.disp = predict();
            if (m_en) m_p = (m_p + 1) % FRAME;
            if (we) begin
               if (addr == 2'd0) m_data = wdata;
               if (addr == 2'd1) m_ext = wdata[4:0];
               if (addr == 2'd2) m_en = wdata[0];
            end
         end
         if (known) begin
            e.data = m_data;
            e.ext = m_ext;
            e.en = m_en;
            q.push_back(e);
         end
      end
   end

   // Monitor: compare pins and readback mid-cycle.
   initial begin
      exp_t e;
      logic [36:0] act;
      logic [31:0] er;
      forever begin
         @(negedge clk);
         if (q.size() > 1) begin
            n_fails++;
            $display("FAIL queue: depth %0d required <= 1", q.size());
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            act = {digital_tube_sel0, digital_tube0,
                   digital_tube_sel1, digital_tube1,
                   digital_tube_sel2, digital_tube2};
            n_checks++;
            if (act !== e.disp) begin
               n_fails++;
               $display("FAIL disp @%0t: got %h required %h", $time, act, e.disp);
            end
            case (addr)
               2'd0: er = e.data;
               2'd1: er = {27'd0, e.ext};
               2'd2: er = {31'd0, e.en};
               default: er = 32'd0;
            endcase
            n_checks++;
            if (rdata !== er) begin
               n_fails++;
               $display("FAIL rdata addr%0d @%0t: got %h required %h",
                        addr, $time, rdata, er);
            end
         end
      end
   end

   task automatic drive(input bit r, input bit w,
                        input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      reset = r;
      we = w;
      addr = a;
      wdata = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
   endtask

   initial begin
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      idle(20);
      drive(1'b0, 1'b1, 2'd0, 32'h1234ABCD);
      idle(20);
      drive(1'b0, 1'b1, 2'd1, 32'h1F);
      idle(3);
      drive(1'b0, 1'b1, 2'd1, 32'h0F);
      idle(3);
      drive(1'b0, 1'b1, 2'd2, 32'h0);
      idle(20);
      drive(1'b0, 1'b1, 2'd2, 32'h1);
      idle(20);
      drive(1'b0, 1'b1, 2'd3, 32'hDEADBEEF);
      drive(1'b0, 1'b0, 2'd3, 32'd0);
      idle(2);
      for (int i = 0; i < 8; i++)
         drive(1'b0, 1'b1, 2'd0, $urandom);
      idle(5);
      drive(1'b1, 1'b1, 2'd0, 32'hCAFEF00D);
      drive(1'b0, 1'b0, 2'd0, 32'd0);
      idle(10);
      for (int i = 0; i < 500; i++) begin
         logic [1:0] a;
         logic [31:0] d;
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, a, d);
      end
      idle(4);
      @(negedge clk);
      #1;
      if (n_checks < 12) begin
         n_fails++;
         $display("FAIL count: %0d checks required >= 12", n_checks);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
